// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the PWM configuration scheduler:
// register map, RAMP_CTRL bit positions and ramp FSM encoding.
package pwm_cfg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI  = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI  = 7'h03;
    localparam logic [6:0] ADDR_DUTY       = 7'h04;
    localparam logic [6:0] ADDR_RAMP_CTRL  = 7'h05;
    localparam logic [6:0] ADDR_RAMP_STEP  = 7'h06;
    localparam logic [6:0] ADDR_RAMP_DIV   = 7'h07;

    localparam int RAMP_CTRL_EN_BIT   = 0;
    localparam int RAMP_CTRL_MODE_BIT = 1;

    typedef enum logic [1:0] {
        RAMP_OFF  = 2'b00,
        RAMP_UP   = 2'b01,
        RAMP_DOWN = 2'b10
    } ramp_state_t;

    typedef enum logic {
        MODE_SAWTOOTH = 1'b0,
        MODE_TRIANGLE = 1'b1
    } ramp_mode_t;

endpackage

// File: rtl/pwm_ramp_gen.sv
// Duty-ramp engine: state machine, period divider and step arithmetic.
// Produces the stepped duty value and a tick; the owner decides whether to apply it.
module pwm_ramp_gen
    import pwm_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        period_end,
    input  logic        suppress,
    input  logic        ctrl_wr,
    input  logic        ctrl_enable,
    input  ramp_mode_t  mode,
    input  logic [7:0]  duty,
    input  logic [7:0]  step,
    input  logic [7:0]  div,
    output logic [7:0]  next_duty,
    output logic        ramp_tick,
    output ramp_state_t state
);

    ramp_state_t step_state;
    logic [7:0]  div_cnt;
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic        disable_wr;

    assign disable_wr = ctrl_wr && !ctrl_enable;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        sum9       = {1'b0, duty} + {1'b0, step};
        diff9      = {1'b0, duty} - {1'b0, step};
        next_duty  = duty;
        step_state = state;
        ramp_tick  = (state != RAMP_OFF) && period_end && (div_cnt == div) && !disable_wr;
        case (state)
            RAMP_UP: begin
                if (mode == MODE_TRIANGLE && sum9 >= 9'd255) begin
                    next_duty  = 8'hFF;
                    step_state = RAMP_DOWN;
                end else begin
                    next_duty = sum9[7:0];
                end
            end
            RAMP_DOWN: begin
                // Leaving triangle mode mid-descent: turn around without stepping.
                if (mode == MODE_SAWTOOTH) begin
                    step_state = RAMP_UP;
                end else if (diff9[8] || diff9 == 9'd0) begin
                    next_duty  = 8'h00;
                    step_state = RAMP_UP;
                end else begin
                    next_duty = diff9[7:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state   <= RAMP_OFF;
            div_cnt <= 8'd0;
        end else if (disable_wr) begin
            state   <= RAMP_OFF;
            div_cnt <= 8'd0;
        end else if (ctrl_wr && state == RAMP_OFF) begin
            state   <= RAMP_UP;
            div_cnt <= 8'd0;
        end else if (state != RAMP_OFF && period_end) begin
            if (ramp_tick) begin
                div_cnt <= 8'd0;
                if (!suppress) begin
                    state <= step_state;
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// PWM configuration register set: SPI write decode, duty shadow/pending commit at
// period boundaries, and arbitration between SPI duty writes and the ramp engine.
module pwm_cfg_scheduler
    import pwm_cfg_pkg::*;
#(
    parameter logic [7:0] DUTY_RESET   = 8'h00,
    parameter int         NUM_CFG_REGS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_wr_valid,
    input  logic [6:0] spi_wr_addr,
    input  logic [7:0] spi_wr_data,
    input  logic       pwm_period_end,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic [1:0] ramp_state,
    output logic       wr_err
);

    localparam logic [7:0] NUM_REGS = 8'(NUM_CFG_REGS);

    logic        addr_ok;
    logic        reg_wr;
    logic        duty_wr;
    logic        ctrl_wr;
    logic        suppress;
    logic        pending;
    logic [7:0]  shadow;
    logic [7:0]  ramp_step;
    logic [7:0]  ramp_div;
    ramp_mode_t  ramp_mode;
    logic [7:0]  next_duty;
    logic        ramp_tick;
    ramp_state_t fsm_state;

    assign addr_ok  = ({1'b0, spi_wr_addr} < NUM_REGS);
    assign reg_wr   = spi_wr_valid && addr_ok;
    assign duty_wr  = reg_wr && (spi_wr_addr == ADDR_DUTY);
    assign ctrl_wr  = reg_wr && (spi_wr_addr == ADDR_RAMP_CTRL);
    // SPI owns any boundary where it has a duty value to commit.
    assign suppress = pwm_period_end && (pending || duty_wr);

    assign ramp_state = fsm_state;

    pwm_ramp_gen u_ramp (
        .clk         (clk),
        .rst         (rst),
        .period_end  (pwm_period_end),
        .suppress    (suppress),
        .ctrl_wr     (ctrl_wr),
        .ctrl_enable (spi_wr_data[RAMP_CTRL_EN_BIT]),
        .mode        (ramp_mode),
        .duty        (pwm_duty_cycle),
        .step        (ramp_step),
        .div         (ramp_div),
        .next_duty   (next_duty),
        .ramp_tick   (ramp_tick),
        .state       (fsm_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            ramp_mode       <= MODE_SAWTOOTH;
            ramp_step       <= 8'h00;
            ramp_div        <= 8'h00;
            wr_err          <= 1'b0;
            pwm_duty_cycle  <= DUTY_RESET;
            shadow          <= DUTY_RESET;
            pending         <= 1'b0;
        end else begin
            wr_err <= spi_wr_valid && !addr_ok;

            if (reg_wr) begin
                case (spi_wr_addr)
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= spi_wr_data;
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= spi_wr_data;
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= spi_wr_data;
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= spi_wr_data;
                    ADDR_RAMP_CTRL: ramp_mode <= ramp_mode_t'(spi_wr_data[RAMP_CTRL_MODE_BIT]);
                    ADDR_RAMP_STEP: ramp_step <= spi_wr_data;
                    ADDR_RAMP_DIV:  ramp_div  <= spi_wr_data;
                    default: ;
                endcase
            end

            // Duty only ever moves on a period_end edge; priority: bypass, pending, ramp.
            if (pwm_period_end && duty_wr) begin
                pwm_duty_cycle <= spi_wr_data;
                shadow         <= spi_wr_data;
                pending        <= 1'b0;
            end else if (pwm_period_end && pending) begin
                pwm_duty_cycle <= shadow;
                pending        <= 1'b0;
            end else if (duty_wr) begin
                shadow  <= spi_wr_data;
                pending <= 1'b1;
            end else if (ramp_tick) begin
                pwm_duty_cycle <= next_duty;
                shadow         <= next_duty;
            end
        end
    end

endmodule
